// File: rtl/vec_feed_fifo_pkg.sv
// ----------------------------------------------------------------------------
// vec_feed_pkg
//   Shared types and helpers for the vec_feed_fifo slice.
//   - vec_beat_t : one beat of the mixed signed/unsigned vector stage inputs,
//                  shown at the default width. The FIFO declares its own copy
//                  sized by its WIDTH parameter, because a package typedef
//                  cannot follow a module parameter.
//   - next_ptr   : modulo-depth increment for pointers of any depth, including
//                  depths that are not powers of two.
// ----------------------------------------------------------------------------
package vec_feed_pkg;

    localparam int VEC_WIDTH_DEF = 32;

    typedef struct packed {
        logic signed [VEC_WIDTH_DEF-1:3] svec;
        logic        [VEC_WIDTH_DEF-1:0] uvec;
        logic signed                     s;
        logic                            u;
    } vec_beat_t;

    // Wraps depth-1 back to 0, so the pointer never reaches a value >= depth.
    function automatic int unsigned next_ptr(input int unsigned ptr,
                                             input int unsigned depth);
        return (ptr + 1 >= depth) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/vec_feed_fifo_if.sv
// ----------------------------------------------------------------------------
// vec_feed_fifo_if
//   Producer and consumer ready/valid handshakes of vec_feed_fifo.
//   slave  : FIFO view (accepts in_*, presents out_*)
//   master : environment view (drives in_*, consumes out_*)
//   Signals:
//     in_valid/in_ready    producer handshake
//     in_signed_vec        signed   [WIDTH-1:3] payload
//     in_unsigned_vec      unsigned [WIDTH-1:0] payload
//     in_signed            signed scalar payload
//     in_unsigned          unsigned scalar payload
//     out_valid/out_ready  consumer handshake
//     out_*                head entry, zero while out_valid=0
// ----------------------------------------------------------------------------
interface vec_feed_fifo_if #(
    parameter int WIDTH = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:3] in_signed_vec;
    logic        [WIDTH-1:0] in_unsigned_vec;
    logic signed             in_signed;
    logic                    in_unsigned;

    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:3] out_signed_vec;
    logic        [WIDTH-1:0] out_unsigned_vec;
    logic signed             out_signed;
    logic                    out_unsigned;

    modport slave (
        input  in_valid, in_signed_vec, in_unsigned_vec, in_signed, in_unsigned,
        output in_ready,
        output out_valid, out_signed_vec, out_unsigned_vec, out_signed, out_unsigned,
        input  out_ready
    );

    modport master (
        output in_valid, in_signed_vec, in_unsigned_vec, in_signed, in_unsigned,
        input  in_ready,
        input  out_valid, out_signed_vec, out_unsigned_vec, out_signed, out_unsigned,
        output out_ready
    );
endinterface

// File: rtl/vec_feed_fifo_mod_ptr.sv
// ----------------------------------------------------------------------------
// mod_ptr
//   Modulo-DEPTH pointer used for both the write and the read side.
//   Ports:
//     clk    in  clock
//     rst_n  in  synchronous active-low reset, pointer -> 0
//     clr_i  in  synchronous clear, wins over inc_i
//     inc_i  in  advance by one, DEPTH-1 wraps to 0
//     ptr_o  out current pointer value
// ----------------------------------------------------------------------------
module mod_ptr
    import vec_feed_pkg::*;
#(
    parameter  int DEPTH = 13,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = PTR_W'(next_ptr(32'(ptr_q), DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/vec_feed_fifo.sv
// ----------------------------------------------------------------------------
// vec_feed_fifo
//   First-word-fall-through ready/valid buffer of DEPTH entries (any DEPTH>=2)
//   feeding the mixed signed/unsigned vector passthrough stage.
//   Ports:
//     clk    in  clock, all state on posedge
//     rst_n  in  synchronous active-low reset (pointers, level, flags)
//     flush  in  synchronous clear of contents, wins over push and pop
//     bus    slave modport of vec_feed_fifo_if (producer and consumer sides)
//     level  out entries held, 0..DEPTH
// ----------------------------------------------------------------------------
module vec_feed_fifo
    import vec_feed_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 13,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    vec_feed_fifo_if.slave   bus,
    output logic [CNT_W-1:0] level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic signed [WIDTH-1:3] svec;
        logic        [WIDTH-1:0] uvec;
        logic signed             s;
        logic                    u;
    } beat_t;

    beat_t            mem_q [DEPTH];
    logic [CNT_W-1:0] level_q;
    logic [CNT_W-1:0] level_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic             in_ready;
    beat_t            wr_beat;
    beat_t            head;

    // in_ready is a registered flag; gating with rst_n only pulls it low while
    // reset is asserted, it never opens a path from in_* or out_ready.
    assign in_ready = in_ready_q & rst_n;
    assign push     = bus.in_valid & in_ready;
    assign pop      = out_valid_q & bus.out_ready;

    assign wr_beat.svec = bus.in_signed_vec;
    assign wr_beat.uvec = bus.in_unsigned_vec;
    assign wr_beat.s    = bus.in_signed;
    assign wr_beat.u    = bus.in_unsigned;

    mod_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (flush),
        .inc_i (push),
        .ptr_o (wr_ptr)
    );

    mod_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (flush),
        .inc_i (pop),
        .ptr_o (rd_ptr)
    );

    always_comb begin
        level_d = level_q;
        if (flush) begin
            level_d = '0;
        end else if (push && !pop) begin
            level_d = level_q + CNT_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - CNT_W'(1);
        end
    end

    // Flags are precomputed from the next level so they match level_q exactly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            level_q     <= level_d;
            in_ready_q  <= (level_d != CNT_W'(DEPTH));
            out_valid_q <= (level_d != '0);
        end
    end

    // Storage is not reset; a flushed beat is simply never written.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr] <= wr_beat;
        end
    end

    // FWFT head, zeroed while empty so stale memory never leaks out.
    assign head = out_valid_q ? mem_q[rd_ptr] : '0;

    assign bus.in_ready         = in_ready;
    assign bus.out_valid        = out_valid_q;
    assign bus.out_signed_vec   = head.svec;
    assign bus.out_unsigned_vec = head.uvec;
    assign bus.out_signed       = head.s;
    assign bus.out_unsigned     = head.u;
    assign level                = level_q;

endmodule
